// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the AXI burst write master.
// State encoding, AXI response codes and a width helper.
package axi_wr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_AW,
    S_W,
    S_WAIT_B,
    S_DONE
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] AWBURST_INCR = 2'b01;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_bresp_tracker.sv
// Outstanding write-response counter with bready and sticky error.
// Counts bursts whose last beat went out and whose BRESP is pending.
module axi_bresp_tracker
  import axi_wr_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       err_clr,
  input  logic       bvalid,
  input  logic [1:0] bresp,
  output logic       bready,
  output logic       full,
  output logic       empty,
  output logic       last_ack,
  output logic       err
);

  localparam int CW = clog2(MAX_OUTST + 1);

  logic [CW-1:0] cnt_q;
  logic          dec;

  assign bready   = (cnt_q != '0);
  assign dec      = bvalid & bready;
  assign full     = (cnt_q == CW'(MAX_OUTST));
  assign empty    = (cnt_q == '0);
  assign last_ack = dec & ~inc & (cnt_q == CW'(1));

  // Outstanding count; simultaneous inc and dec cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && !dec) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (dec && !inc) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Sticky error: set by an error response, cleared on a new request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (dec && (bresp == SLVERR || bresp == DECERR)) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_burst_wr_master.sv
// AXI4 write master: splits a request into INCR bursts that stay
// inside a boundary line, streams data and tracks write responses.
module axi_burst_wr_master
  import axi_wr_pkg::*;
#(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16,
  parameter int MAX_OUTST  = 4,
  parameter int BOUNDARY   = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_trig,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [LEN_WIDTH-1:0]    wr_len,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_data_valid,
  output logic                    wr_data_ready,
  output logic                    wr_ready,
  output logic                    wr_done,
  output logic                    wr_err,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic [2:0]              axi_awsize,
  output logic [1:0]              axi_awburst,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  input  logic [1:0]              axi_bresp
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] AMASK =
    {ADDR_WIDTH{1'b1}} << OFF;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [8:0]            beats_q;
  logic [8:0]            cnt_q;
  logic [31:0]           line_off;
  logic [31:0]           line_left;
  logic [31:0]           calc;
  logic                  accept;
  logic                  w_hs;
  logic                  is_last;
  logic                  last_hs;
  logic                  more;
  logic                  full;
  logic                  empty;
  logic                  last_ack;

  assign axi_awsize  = 3'(OFF);
  assign axi_awburst = AWBURST_INCR;
  assign axi_wdata   = wr_data;
  assign axi_wstrb   = '1;

  assign accept  = wr_trig & (wr_len != '0);
  assign w_hs    = (state_q == S_W) & wr_data_valid & axi_wready;
  assign is_last = (cnt_q == beats_q - 9'd1);
  assign last_hs = w_hs & is_last;
  assign more    = (rem_q != LEN_WIDTH'(beats_q));

  // Burst size: min of remaining, max burst and room left in the line.
  always_comb begin
    line_off  = 32'(addr_q) & 32'(BOUNDARY - 1);
    line_left = (32'(BOUNDARY) - line_off) >> OFF;
    calc      = 32'(rem_q);
    if (calc > 32'(MAX_BURST)) calc = 32'(MAX_BURST);
    if (calc > line_left) calc = line_left;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    wr_ready      = 1'b0;
    wr_done       = 1'b0;
    axi_awvalid   = 1'b0;
    axi_wvalid    = 1'b0;
    wr_data_ready = 1'b0;
    axi_wlast     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        wr_ready = 1'b1;
        if (accept) state_d = S_CALC;
      end
      S_CALC: begin
        if (!full) state_d = S_AW;
      end
      S_AW: begin
        axi_awvalid = 1'b1;
        if (axi_awready) state_d = S_W;
      end
      S_W: begin
        axi_wvalid    = wr_data_valid;
        wr_data_ready = axi_wready;
        axi_wlast     = is_last;
        if (last_hs) state_d = more ? S_CALC : S_WAIT_B;
      end
      S_WAIT_B: begin
        if (empty || last_ack) state_d = S_DONE;
      end
      S_DONE: begin
        wr_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address, remaining beats, burst size and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      cnt_q      <= '0;
      axi_awaddr <= '0;
      axi_awlen  <= '0;
    end else begin
      if (state_q == S_IDLE && accept) begin
        addr_q <= wr_addr & AMASK;
        rem_q  <= wr_len;
      end
      if (state_q == S_CALC) begin
        beats_q    <= 9'(calc);
        axi_awaddr <= addr_q;
        axi_awlen  <= 8'(calc - 32'd1);
        cnt_q      <= '0;
      end
      if (w_hs) cnt_q <= cnt_q + 9'd1;
      if (last_hs) begin
        rem_q  <= rem_q - LEN_WIDTH'(beats_q);
        addr_q <= addr_q + (ADDR_WIDTH'(beats_q) << OFF);
      end
    end
  end

  axi_bresp_tracker #(
    .MAX_OUTST (MAX_OUTST)
  ) u_bresp (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (last_hs),
    .err_clr  ((state_q == S_IDLE) && accept),
    .bvalid   (axi_bvalid),
    .bresp    (axi_bresp),
    .bready   (axi_bready),
    .full     (full),
    .empty    (empty),
    .last_ack (last_ack),
    .err      (wr_err)
  );

endmodule

// File: tb/tb_axi_burst_wr_master.sv
// Scoreboard bench for axi_burst_wr_master with random handshakes
// and a burst-splitting reference model.
module tb_axi_burst_wr_master;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int MB = 16;
  localparam int MO = 2;
  localparam int BD = 4096;

  logic          clk;
  logic          rst_n;
  logic          wr_trig;
  logic [AW-1:0] wr_addr;
  logic [LW-1:0] wr_len;
  logic [DW-1:0] wr_data;
  logic          wr_data_valid;
  logic          wr_data_ready;
  logic          wr_ready;
  logic          wr_done;
  logic          wr_err;
  logic          axi_awvalid;
  logic          axi_awready;
  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic [2:0]    axi_awsize;
  logic [1:0]    axi_awburst;
  logic          axi_wvalid;
  logic          axi_wready;
  logic [DW-1:0] axi_wdata;
  logic [3:0]    axi_wstrb;
  logic          axi_wlast;
  logic          axi_bvalid;
  logic          axi_bready;
  logic [1:0]    axi_bresp;

  axi_burst_wr_master #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .MAX_BURST  (MB),
    .MAX_OUTST  (MO),
    .BOUNDARY   (BD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_trig       (wr_trig),
    .wr_addr       (wr_addr),
    .wr_len        (wr_len),
    .wr_data       (wr_data),
    .wr_data_valid (wr_data_valid),
    .wr_data_ready (wr_data_ready),
    .wr_ready      (wr_ready),
    .wr_done       (wr_done),
    .wr_err        (wr_err),
    .axi_awvalid   (axi_awvalid),
    .axi_awready   (axi_awready),
    .axi_awaddr    (axi_awaddr),
    .axi_awlen     (axi_awlen),
    .axi_awsize    (axi_awsize),
    .axi_awburst   (axi_awburst),
    .axi_wvalid    (axi_wvalid),
    .axi_wready    (axi_wready),
    .axi_wdata     (axi_wdata),
    .axi_wstrb     (axi_wstrb),
    .axi_wlast     (axi_wlast),
    .axi_bvalid    (axi_bvalid),
    .axi_bready    (axi_bready),
    .axi_bresp     (axi_bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [33:0] exp_aw[$];
  logic [32:0] exp_w[$];
  logic        exp_done[$];
  logic [31:0] src_q[$];
  logic [1:0]  bresp_q[$];
  int          b_pend;
  bit          b_en;
  int          aw_hs;
  int          done_cnt;
  int          n_cmp;
  int          n_bad;
  bit          prev_done;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no expected entry or timed out", name);
  endtask

  // Monitor: pops expectations whenever the DUT shows a handshake.
  always @(negedge clk) begin
    logic [33:0] ea;
    logic [32:0] ew;
    logic        ed;
    if (rst_n) begin
      if (axi_awvalid && axi_awready) begin
        aw_hs++;
        check("aw_attr", {axi_awsize, axi_awburst}, {3'd2, 2'b01});
        if (exp_aw.size() == 0) miss("aw_extra");
        else begin
          ea = exp_aw.pop_front();
          check("aw", {axi_awaddr, axi_awlen}, ea);
        end
      end
      if (axi_wvalid) check("wvalid_gate", wr_data_valid, 1);
      if (axi_wvalid && axi_wready) begin
        check("wstrb", axi_wstrb, 4'hf);
        if (exp_w.size() == 0) miss("w_extra");
        else begin
          ew = exp_w.pop_front();
          check("w", {axi_wlast, axi_wdata}, ew);
        end
      end
      if (wr_done) begin
        done_cnt++;
        check("done_pulse", prev_done, 0);
        if (exp_done.size() == 0) miss("done_extra");
        else begin
          ed = exp_done.pop_front();
          check("wr_err", wr_err, ed);
        end
      end
      prev_done = wr_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Environment: user data source, AW/W ready and BRESP slave.
  initial begin
    bit bhs;
    wr_data_valid = 1'b0;
    wr_data       = '0;
    axi_awready   = 1'b0;
    axi_wready    = 1'b0;
    axi_bvalid    = 1'b0;
    axi_bresp     = 2'b00;
    forever begin
      @(negedge clk);
      bhs = 1'b0;
      if (rst_n) begin
        if (wr_data_valid && wr_data_ready && src_q.size() != 0)
          void'(src_q.pop_front());
        bhs = axi_bvalid && axi_bready;
        if (bhs) begin
          b_pend--;
          if (bresp_q.size() != 0) void'(bresp_q.pop_front());
        end
        if (axi_wvalid && axi_wready && axi_wlast) b_pend++;
      end
      @(posedge clk);
      #1;
      wr_data_valid = (src_q.size() != 0) && ($urandom_range(3) != 0);
      wr_data       = (src_q.size() != 0) ? src_q[0] : '0;
      axi_wready    = ($urandom_range(3) != 0);
      axi_awready   = ($urandom_range(2) != 0);
      if (!axi_bvalid || bhs || b_pend <= 0) begin
        axi_bvalid = b_en && (b_pend > 0) && ($urandom_range(1) == 1);
        axi_bresp  = (bresp_q.size() != 0) ? bresp_q[0] : 2'b00;
      end
    end
  end

  // Reference model: split the request and queue expectations.
  // mode 0: all OKAY, 1: second burst SLVERR, 2: random codes.
  task automatic plan(input logic [AW-1:0] a, input int len,
                      input int mode);
    logic [AW-1:0] p;
    logic [1:0]    r;
    logic [31:0]   d;
    int            rem;
    int            b;
    int            room;
    int            k;
    bit            err;
    p   = a & ~26'h3;
    rem = len;
    k   = 0;
    err = 1'b0;
    while (rem > 0) begin
      room = (BD - (int'(p) % BD)) / 4;
      b = rem;
      if (b > MB) b = MB;
      if (b > room) b = room;
      exp_aw.push_back({p, 8'(b - 1)});
      for (int j = 0; j < b; j++) begin
        d = $urandom;
        src_q.push_back(d);
        exp_w.push_back({(j == b - 1), d});
      end
      if (mode == 1) r = (k == 1) ? 2'b10 : 2'b00;
      else if (mode == 2) r = 2'($urandom_range(3));
      else r = 2'b00;
      bresp_q.push_back(r);
      err = err | r[1];
      p   = p + AW'(b * 4);
      rem = rem - b;
      k++;
    end
    exp_done.push_back(err);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!wr_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) miss("idle_timeout");
  endtask

  // Present one request; optionally check CALC and AW latency.
  task automatic issue(input logic [AW-1:0] a, input int len,
                       input int mode, input bit chk);
    wait_idle();
    @(posedge clk);
    #1;
    wr_trig = 1'b1;
    wr_addr = a;
    wr_len  = LW'(len);
    if (len != 0) plan(a, len, mode);
    @(posedge clk);
    #1;
    wr_trig = 1'b0;
    if (chk) begin
      @(negedge clk);
      check("calc_ready", wr_ready, 0);
      check("calc_err_clr", wr_err, 0);
      check("calc_awvalid", axi_awvalid, 0);
      @(negedge clk);
      check("aw_latency", axi_awvalid, 1);
    end
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) miss("done_timeout");
    check("aw_drained", exp_aw.size(), 0);
    check("w_drained", exp_w.size(), 0);
  endtask

  task automatic run(input logic [AW-1:0] a, input int len,
                     input int mode, input bit chk);
    int d0;
    d0 = done_cnt;
    issue(a, len, mode, chk);
    wait_done(d0);
  endtask

  initial begin
    int d0;
    int a0;
    int n;
    logic [AW-1:0] ra;
    rst_n    = 1'b0;
    wr_trig  = 1'b0;
    wr_addr  = '0;
    wr_len   = '0;
    b_en     = 1'b1;
    b_pend   = 0;
    aw_hs    = 0;
    done_cnt = 0;
    n_cmp    = 0;
    n_bad    = 0;

    #12;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_wr_done", wr_done, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_awvalid", axi_awvalid, 0);
    check("rst_wvalid", axi_wvalid, 0);
    check("rst_bready", axi_bready, 0);
    check("rst_awaddr", axi_awaddr, 0);
    check("rst_awlen", axi_awlen, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run(26'h100, 40, 0, 1);
    run(26'hFF8, 4, 0, 1);
    run(26'h3FFFFF0, 10, 0, 0);

    // Response stall: only MO bursts may be waiting for BRESP.
    b_en = 1'b0;
    d0 = done_cnt;
    a0 = aw_hs;
    issue(26'h0, 64, 0, 1);
    n = 0;
    while (b_pend < MO && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (b_pend < MO) miss("stall_timeout");
    repeat (8) @(negedge clk);
    check("stall_aw_count", aw_hs - a0, MO);
    check("stall_awvalid", axi_awvalid, 0);
    check("stall_bready", axi_bready, 1);
    b_en = 1'b1;
    wait_done(d0);
    check("stall_total_aw", aw_hs - a0, 4);

    run(26'h2A4, 20, 0, 1);
    run(26'h0, 48, 1, 1);
    run(26'h1234, 25, 0, 1);

    for (int i = 0; i < 8; i++) begin
      ra = AW'($urandom);
      if (i % 2 == 1) ra[11:0] = 12'hF00 | 12'($urandom_range(63) * 4);
      run(ra, $urandom_range(1, 70), 2, 0);
    end

    // Asynchronous reset in the middle of a data phase.
    issue(26'h200, 40, 0, 0);
    n = 0;
    while (exp_w.size() > 34 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_w.size() > 34) miss("midw_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wr_ready", wr_ready, 1);
    check("arst_awvalid", axi_awvalid, 0);
    check("arst_wvalid", axi_wvalid, 0);
    check("arst_wlast", axi_wlast, 0);
    check("arst_bready", axi_bready, 0);
    check("arst_data_ready", wr_data_ready, 0);
    check("arst_awlen", axi_awlen, 0);
    exp_aw.delete();
    exp_w.delete();
    exp_done.delete();
    src_q.delete();
    bresp_q.delete();
    b_pend = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    a0 = aw_hs;
    d0 = done_cnt;
    issue(26'h40, 0, 0, 0);
    repeat (6) @(negedge clk);
    check("len0_ready", wr_ready, 1);
    check("len0_no_aw", aw_hs - a0, 0);
    check("len0_no_done", done_cnt - d0, 0);

    run(26'h80, 5, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_burst_wr_master.md
Name: axi_burst_wr_master

Overview:
Parametrised AXI4 write master and successor of the single-burst write master.
- Accepts one user write request: start byte address plus total beat count.
- Splits the request into AXI INCR bursts of at most MAX_BURST beats; no burst crosses a BOUNDARY-byte line.
- Streams user data through a valid/ready interface, keeps up to MAX_OUTST write responses outstanding, reports BRESP errors.
- Sits between the user/DMA logic and the DDR2 controller AXI slave port.

Parameters:
- ADDR_WIDTH, 26, byte address width.
- DATA_WIDTH, 32, data bus width; power of two, 8..1024.
- LEN_WIDTH, 16, width of the total-beat-count request field.
- MAX_BURST, 16, maximum beats per burst; 1..256.
- MAX_OUTST, 4, maximum bursts with last beat sent and BRESP not yet received; 1..15.
- BOUNDARY, 4096, burst-crossing boundary in bytes; power of two, at least MAX_BURST*DATA_WIDTH/8.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous active-low reset.
- wr_trig, in, 1: request strobe; sampled only while wr_ready=1.
- wr_addr, in, ADDR_WIDTH: start byte address; low log2(DATA_WIDTH/8) bits ignored (forced to 0).
- wr_len, in, LEN_WIDTH: total beats; 0 means the request is ignored.
- wr_data, in, DATA_WIDTH: write data.
- wr_data_valid, in, 1: wr_data valid.
- wr_data_ready, out, 1: beat consumed this cycle.
- wr_ready, out, 1: idle, request accepted.
- wr_done, out, 1: one-cycle pulse, request fully complete.
- wr_err, out, 1: sticky; some BRESP of the current/last request was SLVERR or DECERR.
- axi_awvalid, out, 1: write address valid.
- axi_awready, in, 1: write address ready.
- axi_awaddr, out, ADDR_WIDTH: burst start byte address.
- axi_awlen, out, 8: beats-1.
- axi_awsize, out, 3: constant log2(DATA_WIDTH/8).
- axi_awburst, out, 2: constant 2'b01 (INCR).
- axi_wvalid, out, 1: write data valid.
- axi_wready, in, 1: write data ready.
- axi_wdata, out, DATA_WIDTH: write data.
- axi_wstrb, out, DATA_WIDTH/8: all ones.
- axi_wlast, out, 1: last beat of burst.
- axi_bvalid, in, 1: write response valid.
- axi_bready, out, 1: write response ready.
- axi_bresp, in, 2: write response code.

Behaviour:
- Reset (async, rst_n=0): state IDLE; wr_ready=1; wr_done, wr_err, wr_data_ready, axi_awvalid, axi_wvalid, axi_wlast, axi_bready = 0; axi_awaddr, axi_awlen = 0; remaining, outstanding and beat counters = 0. Reset mid-burst abandons the transfer with no completion.
- States: IDLE, CALC, AW, W, WAIT_B, DONE.
- IDLE: wr_trig & wr_len!=0 -> latch aligned address and remaining=wr_len, clear wr_err, go CALC.
- CALC (1 cycle minimum):
  - Registers beats = min(remaining, MAX_BURST, (BOUNDARY - addr mod BOUNDARY) / (DATA_WIDTH/8)).
  - Loads axi_awaddr=addr and axi_awlen=beats-1.
  - Stays in CALC while outstanding == MAX_OUTST; otherwise asserts axi_awvalid and goes AW.
- AW: axi_awvalid held with stable address/len until axi_awready; on handshake deassert and go W.
- W:
  - axi_wvalid = wr_data_valid; wr_data_ready = axi_wready; axi_wdata = wr_data (combinational pass-through).
  - Beat counter increments on each wvalid&wready; axi_wlast=1 when count == beats-1.
  - On last-beat handshake: remaining -= beats; addr += beats*DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH; outstanding increments.
  - Next state: CALC if remaining != 0, else WAIT_B.
  - wr_data_ready=0 outside W.
- Response path:
  - axi_bready = (outstanding != 0).
  - bvalid&bready decrements outstanding. Simultaneous increment and decrement leaves it unchanged.
  - bvalid&bready with axi_bresp[1]=1 sets wr_err.
  - bvalid while outstanding==0 is not acknowledged.
- WAIT_B: go DONE when outstanding == 0, including the cycle the final BRESP handshakes.
- DONE: wr_done=1 for one cycle, then IDLE. wr_err stays valid until the next accepted request.
- wr_trig outside IDLE is ignored.
- Latency: request to first axi_awvalid = 2 cycles, with IDLE and CALC registered.

Decomposition:
- Package axi_wr_pkg:
  - state encoding;
  - BRESP constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - AWBURST_INCR constant;
  - clog2 function for axi_awsize and byte-offset width.
- Sub-module axi_bresp_tracker: outstanding counter (inc/dec/simultaneous), axi_bready generation, sticky error flag with clear, full and empty outputs.

Test Plan:
- DATA_WIDTH=32, MAX_BURST=16: wr_addr=0x100, wr_len=40 -> three AW: (0x100,len 15), (0x140,15), (0x180,7); 40 W beats; wlast on beats 16, 32, 40; wr_done one cycle after third BRESP.
- wr_addr=0xFF8, wr_len=4 -> two AW: (0xFF8,len 1), (0x1000,len 1); no burst crosses 4 KB.
- MAX_OUTST=2, bvalid held 0, wr_len=64 -> exactly 2 bursts sent, then CALC stalls with awvalid=0; releasing one BRESP starts the third AW.
- Random wr_data_valid/axi_wready gaps, wr_len=20 -> data order preserved and beat count exact; axi_wvalid never high with wr_data_valid=0.
- Second BRESP=SLVERR on a 3-burst request -> wr_err=1 at completion, wr_done still pulses; next request clears wr_err on acceptance.
- rst_n=0 asynchronously mid-W, then wr_len=0 trigger -> all outputs at reset values immediately; wr_len=0 request leaves wr_ready=1 with no AW issued.
